// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package memory_arbiter_pkg;

  typedef logic [31:0] regval_t;

  // Word returned to fetch when an instruction access times out.
  localparam regval_t Nop = 32'h8000_0000;

  typedef enum logic [1:0] {
    Idle  = 2'd0,
    Instr = 2'd1,
    Data  = 2'd2
  } arb_state_t;

  function automatic int count_width(input int max_value);
    return (max_value > 0) ? $clog2(max_value + 1) : 1;
  endfunction

endpackage

// File: rtl/memory_arbiter_access_timer.sv
// Bus access timer: loaded on grant, counts down on each m_wait cycle,
// and flags a timeout when a wait cycle arrives with the budget used up.
module memory_arbiter_access_timer
  import memory_arbiter_pkg::*;
#(
  parameter int MaxWait = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic timeout
);

  localparam int CountW = count_width(MaxWait);
  localparam logic [CountW-1:0] Load = CountW'(MaxWait);

  logic [CountW-1:0] remaining;

  always_ff @(posedge clock) begin
    if (reset) begin
      remaining <= '0;
    end else if (clear) begin
      remaining <= Load;
    end else if (tick && (remaining != '0)) begin
      remaining <= remaining - CountW'(1);
    end
  end

  assign timeout = tick && (remaining == '0);

endmodule

// File: rtl/memory_arbiter.sv
// Shares the single memory port between fetch and the write stage, with
// data priority, a starvation guard, wait-state handling and access timeout.
//
//   state | meaning
//   Idle  | no access in flight, arbitrate this cycle
//   Instr | instruction read on the bus
//   Data  | data load or store on the bus
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int MaxWait     = 15,
  parameter int StarveLimit = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_request,
  input  logic [31:0] i_address,
  input  logic        i_cancel,
  output logic        i_ready,
  output logic [31:0] i_data,
  output logic        i_error,
  input  logic        d_request,
  input  logic        d_is_writing,
  input  logic [31:0] d_address,
  input  logic [31:0] d_write_data,
  output logic        d_ready,
  output logic [31:0] d_read_data,
  output logic        d_error,
  output logic [31:0] m_address,
  output logic [31:0] m_write_data,
  output logic        m_read_enable,
  output logic        m_write_enable,
  input  logic        m_wait,
  input  logic [31:0] m_read_data
);

  localparam int StarveW = count_width(StarveLimit);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(StarveLimit);

  arb_state_t         state;
  logic [StarveW-1:0] starve;
  logic               drop;
  logic               i_live;
  logic               d_live;
  logic               grant_i;
  logic               grant_d;
  logic               tick;
  logic               timeout;
  logic               finish;
  logic               drop_now;

  // A requester whose ready is high is still showing its finished request.
  always_comb begin
    i_live   = i_request && !i_ready;
    d_live   = d_request && !d_ready;
    grant_d  = (state == Idle) && d_live && ((starve < StarveMax) || !i_live);
    grant_i  = (state == Idle) && !grant_d && i_live && !i_cancel;
    tick     = (state != Idle) && m_wait;
    finish   = (state != Idle) && (!m_wait || timeout);
    drop_now = drop || i_cancel;
  end

  memory_arbiter_access_timer #(.MaxWait(MaxWait)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (grant_i || grant_d),
    .tick    (tick),
    .timeout (timeout)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= Idle;
      starve         <= '0;
      drop           <= 1'b0;
      m_address      <= '0;
      m_write_data   <= '0;
      m_read_enable  <= 1'b0;
      m_write_enable <= 1'b0;
      i_ready        <= 1'b0;
      i_data         <= '0;
      i_error        <= 1'b0;
      d_ready        <= 1'b0;
      d_read_data    <= '0;
      d_error        <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      i_error <= 1'b0;
      d_ready <= 1'b0;
      d_error <= 1'b0;
      case (state)
        Idle: begin
          if (!i_request || grant_i) begin
            starve <= '0;
          end else if (grant_d && i_live) begin
            starve <= starve + StarveW'(1);
          end
          if (grant_d) begin
            state          <= Data;
            m_address      <= d_address;
            m_write_data   <= d_write_data;
            m_read_enable  <= !d_is_writing;
            m_write_enable <= d_is_writing;
            drop           <= 1'b0;
          end else if (grant_i) begin
            state          <= Instr;
            m_address      <= i_address;
            m_read_enable  <= 1'b1;
            m_write_enable <= 1'b0;
            drop           <= 1'b0;
          end
        end
        Instr: begin
          // Memory cannot abort, so a cancelled fetch runs out and is discarded.
          if (i_cancel) begin
            drop <= 1'b1;
          end
          if (finish) begin
            state         <= Idle;
            m_read_enable <= 1'b0;
            if (!drop_now) begin
              i_ready <= 1'b1;
              i_error <= timeout;
              i_data  <= timeout ? Nop : m_read_data;
            end
          end
        end
        Data: begin
          if (finish) begin
            state          <= Idle;
            m_read_enable  <= 1'b0;
            m_write_enable <= 1'b0;
            d_ready        <= 1'b1;
            d_error        <= timeout;
            d_read_data    <= (timeout || m_write_enable) ? '0 : m_read_data;
          end
        end
        default: state <= Idle;
      endcase
    end
  end

endmodule
